// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - router controller state encoding, default parameters and clog2 helper
package router_pkg;

  // Four-bit state encoding; codes 9..15 are illegal and recover to DECODE_ADDRESS
  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    WAIT_TILL_EMPTY    = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PKT           = 4'd8
  } router_state_e;

  localparam int DEF_NUM_CH       = 3;
  localparam int DEF_ADDR_W       = 2;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_WAIT_TIMEOUT = 30;

  // Ceiling log2 for elaboration-time width calculations
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// rtl/router_wait_timer.sv - saturating wait counter with synchronous clear and terminal-count flag
module router_wait_timer
  import router_pkg::*;
#(
  parameter int TERMINAL = DEF_WAIT_TIMEOUT - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int CNT_W = (clog2(TERMINAL + 1) < 1) ? 1 : clog2(TERMINAL + 1);

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles, hold at terminal count, clear whenever the waiting episode ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else if (clr_i)
      count_q <= '0;
    else if (en_i && !tc_o)
      count_q <= count_q + CNT_W'(1);
  end

  assign tc_o = (count_q == CNT_W'(TERMINAL));

endmodule

// File: rtl/router_ctrl_fsm.sv
// rtl/router_ctrl_fsm.sv - router controller FSM; ROUTER_FSM_TIMEOUT_EN adds the wait-for-empty timeout
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pkt_valid,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic [NUM_CH-1:0] empty,
  output logic              busy,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              drop_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic [ADDR_W-1:0] addr_q,
  output logic              timeout_err
);

  // Per-channel flags widened to the full address space so any address indexes safely
  localparam int SEL_N = 2 ** ADDR_W;

  router_state_e    state_q, state_d;
  logic [SEL_N-1:0] empty_ext, sreset_ext;
  logic [ADDR_W-1:0] hdr_addr;
  logic             hdr_bad, soft_hit, tmo_hit;
  logic             unused_bits;

  assign empty_ext   = SEL_N'(empty);
  assign sreset_ext  = SEL_N'(soft_reset);
  assign hdr_addr    = data_in[ADDR_W-1:0];
  assign hdr_bad     = (int'(hdr_addr) >= NUM_CH);
  assign unused_bits = ^{data_in[DATA_W-1:ADDR_W], WAIT_TIMEOUT > 0};

  // A channel soft reset only aborts a packet that is actually using that channel
  assign soft_hit = sreset_ext[addr_q] &&
                    (state_q != DECODE_ADDRESS) && (state_q != DROP_PKT);

  // Next-state selection; soft reset overrides the normal transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (hdr_bad)                  state_d = DROP_PKT;
          else if (empty_ext[hdr_addr]) state_d = LOAD_FIRST_DATA;
          else                          state_d = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      WAIT_TILL_EMPTY: begin
        if (empty_ext[addr_q]) state_d = LOAD_FIRST_DATA;
        else if (tmo_hit)      state_d = DROP_PKT;
      end
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE:    if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      DROP_PKT:           if (!pkt_valid) state_d = DECODE_ADDRESS;
      default:            state_d = DECODE_ADDRESS;
    endcase
    if (soft_hit) state_d = DECODE_ADDRESS;
  end

  // State register and header address latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (detect_add && pkt_valid) addr_q <= hdr_addr;
    end
  end

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic tmr_tc, timeout_err_q;
  logic in_wait;

  assign in_wait = (state_q == WAIT_TILL_EMPTY);

  router_wait_timer #(
    .TERMINAL (WAIT_TIMEOUT - 1)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .en_i  (in_wait),
    .clr_i (!in_wait || (state_d != WAIT_TILL_EMPTY)),
    .tc_o  (tmr_tc)
  );

  // An empty FIFO on the terminal cycle wins over the timeout
  assign tmo_hit = in_wait && tmr_tc && !empty_ext[addr_q] && !soft_hit;

  // One-cycle error pulse coincident with entry into DROP_PKT on timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err_q <= 1'b0;
    else     timeout_err_q <= tmo_hit;
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign drop_state    = (state_q == DROP_PKT);
  assign write_enb_reg = ld_state || laf_state || (state_q == LOAD_PARITY);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR) && !low_pkt_valid;
  assign busy          = !(detect_add || ld_state || drop_state);

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// tb/tb_router_ctrl_fsm.sv - directed bench for router_ctrl_fsm (timeout steps when ROUTER_FSM_TIMEOUT_EN is defined)
module tb_router_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [2:0] soft_reset, empty;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       drop_state, write_enb_reg, rst_int_reg, timeout_err;
  logic [1:0] addr_q;

  int total = 0;
  int bad   = 0;

  // {busy, detect_add, lfd, ld, laf, full, drop, write_enb, rst_int}
  localparam logic [8:0] S_DEC  = 9'b0_1_0_0_0_0_0_0_0;
  localparam logic [8:0] S_LFD  = 9'b1_0_1_0_0_0_0_0_0;
  localparam logic [8:0] S_LD   = 9'b0_0_0_1_0_0_0_1_0;
  localparam logic [8:0] S_WAIT = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] S_FFS  = 9'b1_0_0_0_0_1_0_0_0;
  localparam logic [8:0] S_LAF  = 9'b1_0_0_0_1_0_0_1_0;
  localparam logic [8:0] S_LP   = 9'b1_0_0_0_0_0_0_1_0;
  localparam logic [8:0] S_CPE  = 9'b1_0_0_0_0_0_0_0_1;
  localparam logic [8:0] S_CPEL = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] S_DROP = 9'b0_0_0_0_0_0_1_0_0;

  wire [8:0] flags = {busy, detect_add, lfd_state, ld_state, laf_state,
                      full_state, drop_state, write_enb_reg, rst_int_reg};

  router_ctrl_fsm #(
    .NUM_CH(3), .ADDR_W(2), .DATA_W(8), .WAIT_TIMEOUT(30)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .pkt_valid(pkt_valid),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .fifo_full(fifo_full), .soft_reset(soft_reset), .empty(empty),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .drop_state(drop_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .addr_q(addr_q), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; data_in = 8'h00; pkt_valid = 1'b0; parity_done = 1'b0;
    low_pkt_valid = 1'b0; fifo_full = 1'b0; soft_reset = 3'b000; empty = 3'b111;
    tick(); tick();
    chk("reset_flags", 32'(flags), 32'(S_DEC));
    chk("reset_addr", 32'(addr_q), 32'd0);
    chk("reset_tmo", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_stays_dec", 32'(flags), 32'(S_DEC));

    // 1: header to ch1, short packet
    data_in = 8'hF1; pkt_valid = 1'b1;
    tick(); chk("t1_lfd", 32'(flags), 32'(S_LFD));
    chk("t1_addr", 32'(addr_q), 32'd1);
    data_in = 8'hAA;
    tick(); chk("t1_ld", 32'(flags), 32'(S_LD));
    chk("t1_addr_held", 32'(addr_q), 32'd1);
    tick(); chk("t1_ld_stay", 32'(flags), 32'(S_LD));
    pkt_valid = 1'b0;
    tick(); chk("t1_lp", 32'(flags), 32'(S_LP));
    tick(); chk("t1_cpe", 32'(flags), 32'(S_CPE));
    tick(); chk("t1_dec", 32'(flags), 32'(S_DEC));

    // 2: header to ch2 while ch2 not empty
    empty = 3'b011; data_in = 8'h02; pkt_valid = 1'b1;
    tick(); chk("t2_wait", 32'(flags), 32'(S_WAIT));
    chk("t2_addr", 32'(addr_q), 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t2_wait_stay", 32'(flags), 32'(S_WAIT));
    end
    empty = 3'b111;
    tick(); chk("t2_lfd", 32'(flags), 32'(S_LFD));
    tick(); chk("t2_ld", 32'(flags), 32'(S_LD));

    // 3: full stall, low_pkt_valid path, CPE back into full, parity_done exit
    fifo_full = 1'b1;
    tick(); chk("t3_ffs", 32'(flags), 32'(S_FFS));
    tick(); chk("t3_ffs_stay", 32'(flags), 32'(S_FFS));
    fifo_full = 1'b0;
    tick(); chk("t3_laf", 32'(flags), 32'(S_LAF));
    low_pkt_valid = 1'b1;
    tick(); chk("t3_lp", 32'(flags), 32'(S_LP));
    tick(); chk("t3_cpe_lowvalid", 32'(flags), 32'(S_CPEL));
    fifo_full = 1'b1;
    tick(); chk("t3_cpe_to_ffs", 32'(flags), 32'(S_FFS));
    fifo_full = 1'b0; low_pkt_valid = 1'b0;
    tick(); chk("t3_laf2", 32'(flags), 32'(S_LAF));
    tick(); chk("t3_laf_to_ld", 32'(flags), 32'(S_LD));
    fifo_full = 1'b1;
    tick(); fifo_full = 1'b0;
    tick(); chk("t3_laf3", 32'(flags), 32'(S_LAF));
    parity_done = 1'b1; pkt_valid = 1'b0;
    tick(); chk("t3_parity_done_dec", 32'(flags), 32'(S_DEC));
    parity_done = 1'b0;

    // 4: out-of-range address is dropped
    data_in = 8'h03; pkt_valid = 1'b1;
    tick(); chk("t4_drop", 32'(flags), 32'(S_DROP));
    chk("t4_addr", 32'(addr_q), 32'd3);
    soft_reset = 3'b111;
    tick(); chk("t4_drop_stay", 32'(flags), 32'(S_DROP));
    soft_reset = 3'b000; pkt_valid = 1'b0;
    tick(); chk("t4_dec", 32'(flags), 32'(S_DEC));

    // 5: soft reset on the selected channel only
    data_in = 8'h01; pkt_valid = 1'b1;
    tick(); tick(); chk("t5_ld", 32'(flags), 32'(S_LD));
    soft_reset = 3'b001;
    tick(); chk("t5_other_ch_ignored", 32'(flags), 32'(S_LD));
    soft_reset = 3'b010;
    tick(); chk("t5_soft_reset_dec", 32'(flags), 32'(S_DEC));
    soft_reset = 3'b000; pkt_valid = 1'b0;
    tick(); chk("t5_dec_idle", 32'(flags), 32'(S_DEC));

    // 6: long wait on ch2
    empty = 3'b011; data_in = 8'h02; pkt_valid = 1'b1;
    tick(); pkt_valid = 1'b0;
    chk("t6_wait", 32'(flags), 32'(S_WAIT));
`ifdef ROUTER_FSM_TIMEOUT_EN
    for (int i = 1; i < 30; i++) begin
      tick();
      chk("t6_wait_hold", 32'(flags), 32'(S_WAIT));
      chk("t6_no_err_yet", 32'(timeout_err), 32'd0);
    end
    tick(); chk("t6_timeout_drop", 32'(flags), 32'(S_DROP));
    chk("t6_err_pulse", 32'(timeout_err), 32'd1);
    tick(); chk("t6_err_cleared", 32'(timeout_err), 32'd0);
    chk("t6_after_drop_dec", 32'(flags), 32'(S_DEC));
    pkt_valid = 1'b1;
    tick(); pkt_valid = 1'b0;
    chk("t6_wait_again", 32'(flags), 32'(S_WAIT));
    for (int i = 0; i < 5; i++) tick();
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("t6_wait_forever", 32'(flags), 32'(S_WAIT));
      chk("t6_err_tied", 32'(timeout_err), 32'd0);
    end
`endif
    #2 rst = 1'b1;
    #1 chk("t6_async_rst", 32'(flags), 32'(S_DEC));
    chk("t6_async_rst_addr", 32'(addr_q), 32'd0);
    tick(); rst = 1'b0; empty = 3'b111;
    tick(); chk("t6_post_rst_dec", 32'(flags), 32'(S_DEC));
    chk("t6_post_rst_err", 32'(timeout_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
